// File: rtl/command_sequencer.sv
// command_sequencer: register-bus command engine.
// Accepts {cmd, addr, value} frames over a valid/ready handshake and turns each
// one into register-file write/read strobes. SET and CLR are read-modify-write
// commands. Every command returns a {status, addr, value} response over a second
// valid/ready handshake. A read that waits too long for data times out, and a
// saturating counter tracks error responses.
//
// Ports:
//   clk, i_reset        clock and synchronous active-high reset
//   i_data, i_valid     incoming frame {cmd, addr, value}, cmd in the MSBs
//   o_ready             frame accepted when i_valid && o_ready at a clock edge
//   o_w_addr/o_w_data   register write address and data
//   o_w_en              one-cycle write strobe
//   o_r_addr/o_r_en     register read address and one-cycle read strobe
//   i_r_data/i_r_valid  read data return
//   o_rsp_data          response frame {status, addr, value}
//   o_rsp_valid         response valid; i_rsp_ready is the response consumer's ready
//   o_err_count         saturating count of nonzero-status responses
module command_sequencer #(
  parameter int unsigned WORD_WIDTH    = 8,
  parameter int unsigned VALUE_WORDS   = 4,
  parameter int unsigned RD_TIMEOUT    = 15,
  parameter int unsigned ERR_CNT_WIDTH = 8,
  parameter logic [WORD_WIDTH-1:0] CMD_READ  = 8'h00,
  parameter logic [WORD_WIDTH-1:0] CMD_WRITE = 8'haa,
  parameter logic [WORD_WIDTH-1:0] CMD_SET   = 8'h55,
  parameter logic [WORD_WIDTH-1:0] CMD_CLR   = 8'h5a
) (
  input  logic                                    clk,
  input  logic                                    i_reset,
  input  logic [(VALUE_WORDS+2)*WORD_WIDTH-1:0]   i_data,
  input  logic                                    i_valid,
  output logic                                    o_ready,
  output logic [WORD_WIDTH-1:0]                   o_w_addr,
  output logic [VALUE_WORDS*WORD_WIDTH-1:0]       o_w_data,
  output logic                                    o_w_en,
  output logic [WORD_WIDTH-1:0]                   o_r_addr,
  output logic                                    o_r_en,
  input  logic [VALUE_WORDS*WORD_WIDTH-1:0]       i_r_data,
  input  logic                                    i_r_valid,
  output logic [(VALUE_WORDS+2)*WORD_WIDTH-1:0]   o_rsp_data,
  output logic                                    o_rsp_valid,
  input  logic                                    i_rsp_ready,
  output logic [ERR_CNT_WIDTH-1:0]                o_err_count
);

  localparam int unsigned VW    = VALUE_WORDS * WORD_WIDTH;
  localparam int unsigned FW    = VW + 2 * WORD_WIDTH;
  localparam int unsigned CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

  localparam logic [WORD_WIDTH-1:0] ST_OK      = WORD_WIDTH'(8'h00);
  localparam logic [WORD_WIDTH-1:0] ST_BAD_CMD = WORD_WIDTH'(8'h01);
  localparam logic [WORD_WIDTH-1:0] ST_TIMEOUT = WORD_WIDTH'(8'h02);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ_REQ,
    S_READ_WAIT,
    S_MODIFY,
    S_RESPOND
  } state_t;

  state_t                   state_q, state_d;
  logic [WORD_WIDTH-1:0]    cmd_q, cmd_d;
  logic [WORD_WIDTH-1:0]    addr_q, addr_d;
  logic [VW-1:0]            value_q, value_d;
  logic [VW-1:0]            w_data_q, w_data_d;
  logic [FW-1:0]            rsp_q, rsp_d;
  logic [CNT_W-1:0]         wait_q, wait_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
  logic                     err_inc;

  logic [WORD_WIDTH-1:0]    frame_cmd;
  logic [WORD_WIDTH-1:0]    frame_addr;
  logic [VW-1:0]            frame_value;

  assign frame_cmd   = i_data[FW-1 -: WORD_WIDTH];
  assign frame_addr  = i_data[VW +: WORD_WIDTH];
  assign frame_value = i_data[VW-1:0];

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    value_d  = value_q;
    w_data_d = w_data_q;
    rsp_d    = rsp_q;
    wait_d   = wait_q;
    err_inc  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          cmd_d   = frame_cmd;
          addr_d  = frame_addr;
          value_d = frame_value;
          if (frame_cmd == CMD_READ || frame_cmd == CMD_SET || frame_cmd == CMD_CLR) begin
            state_d = S_READ_REQ;
          end else if (frame_cmd == CMD_WRITE) begin
            state_d  = S_WRITE;
            w_data_d = frame_value;
          end else begin
            state_d = S_RESPOND;
            rsp_d   = {ST_BAD_CMD, frame_addr, VW'(0)};
            err_inc = 1'b1;
          end
        end
      end

      S_WRITE: begin
        state_d = S_RESPOND;
        rsp_d   = {ST_OK, addr_q, value_q};
      end

      S_READ_REQ: begin
        state_d = S_READ_WAIT;
        wait_d  = '0;
      end

      // Data arriving on the last allowed cycle still counts as data.
      S_READ_WAIT: begin
        if (i_r_valid) begin
          if (cmd_q == CMD_READ) begin
            state_d = S_RESPOND;
            rsp_d   = {ST_OK, addr_q, i_r_data};
          end else begin
            state_d  = S_MODIFY;
            w_data_d = (cmd_q == CMD_SET) ? (i_r_data | value_q) : (i_r_data & ~value_q);
          end
        end else if (wait_q == CNT_W'(RD_TIMEOUT - 1)) begin
          state_d = S_RESPOND;
          rsp_d   = {ST_TIMEOUT, addr_q, VW'(0)};
          err_inc = 1'b1;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end

      S_MODIFY: begin
        state_d = S_RESPOND;
        rsp_d   = {ST_OK, addr_q, w_data_q};
      end

      S_RESPOND: begin
        if (i_rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Saturating error counter
    err_d = err_q;
    if (err_inc && (err_q != {ERR_CNT_WIDTH{1'b1}})) begin
      err_d = err_q + ERR_CNT_WIDTH'(1);
    end
  end

  // State and datapath registers; reset also clears the latched frame
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      addr_q   <= '0;
      value_q  <= '0;
      w_data_q <= '0;
      rsp_q    <= '0;
      wait_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      value_q  <= value_d;
      w_data_q <= w_data_d;
      rsp_q    <= rsp_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
    end
  end

  // Strobes decode from the registered state and are forced low during reset
  assign o_ready     = (state_q == S_IDLE) && !i_reset;
  assign o_r_en      = (state_q == S_READ_REQ) && !i_reset;
  assign o_w_en      = ((state_q == S_WRITE) || (state_q == S_MODIFY)) && !i_reset;
  assign o_rsp_valid = (state_q == S_RESPOND) && !i_reset;

  assign o_w_addr    = addr_q;
  assign o_r_addr    = addr_q;
  assign o_w_data    = w_data_q;
  assign o_rsp_data  = rsp_q;
  assign o_err_count = err_q;

endmodule

// File: doc/command_sequencer.md
Name: command_sequencer

Overview:
Register-bus command engine that succeeds the single-shot command controller. It accepts CAVV frames (command, address, value) over a valid/ready handshake. Frames drive a register file's write and read strobes, including read-modify-write set/clear commands. Every command returns a status/response frame over a second valid/ready handshake, with read-timeout detection and an error counter. It sits between the UART/frame deserialiser and the register file.

Parameters:
WORD_WIDTH, 8, bits per frame word; the command, address and status fields are one word each.
VALUE_WORDS, 4, number of words in the value field; VW = VALUE_WORDS*WORD_WIDTH.
RD_TIMEOUT, 15, maximum READ_WAIT cycles to wait for i_r_valid; must be at least 1.
ERR_CNT_WIDTH, 8, width of the saturating error counter.
CMD_READ, 8'h00, read command code.
CMD_WRITE, 8'haa, write command code.
CMD_SET, 8'h55, read-modify-write OR command code.
CMD_CLR, 8'h5a, read-modify-write AND-NOT command code.

Ports:
clk  in  1  clock
i_reset  in  1  reset, synchronous, active-high
i_data  in  (VALUE_WORDS+2)*WORD_WIDTH  frame {cmd, addr, value}; cmd occupies the MSBs
i_valid  in  1  frame valid
o_ready  out  1  frame accepted when i_valid && o_ready at a clock edge
o_w_addr  out  WORD_WIDTH  register write address
o_w_data  out  VW  register write data
o_w_en  out  1  one-cycle write strobe
o_r_addr  out  WORD_WIDTH  register read address
o_r_en  out  1  one-cycle read strobe
i_r_data  in  VW  read data
i_r_valid  in  1  read data valid
o_rsp_data  out  (VALUE_WORDS+2)*WORD_WIDTH  response frame {status, addr, value}
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  response consumer ready
o_err_count  out  ERR_CNT_WIDTH  saturating count of error responses

Behaviour:
- Reset values: state is IDLE; o_ready, o_w_en, o_r_en and o_rsp_valid are 0 while i_reset is high; all data outputs and o_err_count are 0.
- Frame capture: on acceptance, cmd, addr and value are latched into registers. Later changes on i_data have no effect until the next acceptance.
- Strobes and valids decode from the registered state: o_ready = (state==IDLE) && !i_reset; o_r_en = READ_REQ; o_w_en = WRITE or MODIFY; o_rsp_valid = RESPOND.
- States:
  - IDLE -> on accept: READ/SET/CLR go to READ_REQ; WRITE goes to WRITE; any other code goes to RESPOND with status 0x01.
  - WRITE: one cycle; o_w_addr=addr, o_w_data=value; then RESPOND with status 0x00, value echoed.
  - READ_REQ: one cycle; o_r_addr=addr; then READ_WAIT with the wait counter cleared.
  - READ_WAIT: i_r_valid captures i_r_data. CMD_READ goes to RESPOND (0x00, value=read data). SET/CLR go to MODIFY.
  - READ_WAIT timeout: if no i_r_valid after RD_TIMEOUT cycles in READ_WAIT, go to RESPOND with status 0x02, value 0, and no write.
  - READ_WAIT tie-break: i_r_valid on the final timeout cycle counts as data (data wins).
  - MODIFY: one cycle; o_w_data = rd | value (SET) or rd & ~value (CLR); then RESPOND with status 0x00, value = the written data.
  - RESPOND: o_rsp_data is held stable until i_rsp_ready; the handshake edge moves the block to IDLE.
- i_r_valid outside READ_WAIT is ignored, including late data after a timeout.
- Latency from the accept edge k:
  - WRITE: o_w_en high in cycle k+1; o_rsp_valid from k+2.
  - READ: o_r_en high in cycle k+1.
  - Response: o_rsp_valid one cycle after the i_r_valid edge; MODIFY adds one cycle before it.
- Back-to-back: minimum frame spacing is write 3 cycles and bad-command 2 cycles, each with i_rsp_ready held high.
- o_err_count increments on entry to RESPOND with a nonzero status. It saturates at all-ones and never wraps.
- Reset mid-operation: the next edge returns the block to IDLE. Any pending response or strobe is dropped and the latched frame is cleared. o_ready rises the first cycle after i_reset falls.

Test Plan:
1. Write: frame aa_10_deadbeef, one-cycle i_valid -> o_w_en for exactly 1 cycle with addr 0x10, data deadbeef; then rsp 00_10_deadbeef; o_r_en never asserts.
2. Read: frame 00_22_xxxxxxxx, i_r_valid with 12345678 three cycles after o_r_en -> o_r_en 1 cycle at addr 0x22; rsp 00_22_12345678; no o_w_en.
3. SET/CLR: 55_05_000000f0 with read 0000000f -> o_w_en with 000000ff, rsp 00_05_000000ff. 5a_05_0000000f with read 000000ff -> write and response 000000f0.
4. Timeout: read 00_22 with no i_r_valid -> after 15 READ_WAIT cycles rsp 02_22_00000000; o_err_count=1; i_r_valid two cycles later is ignored; no o_w_en.
5. Bad command 7e_31_... -> rsp 01_31_00000000, no strobes, o_err_count increments. Preset the counter to 0xff -> it stays 0xff.
6. Backpressure and reset:
   - Hold i_rsp_ready low for 10 cycles -> o_rsp_data stable, o_ready 0, a second frame held on i_valid is not accepted until after the handshake.
   - Assert i_reset during RESPOND -> o_rsp_valid is 0 the next cycle; o_ready is 1 the cycle after release.
